inst_encoder: RTL and testbench
===============================

// Module: inst_encoder
// PURPOSE
//  Inverse of the RV32I decode stage: packs decoded micro-op fields into 32-bit RV32I instruction words.
//  Streams encoded words, each with a word address, into instruction memory.
//  Used by the boot/program-load path and by self-checking benches that round-trip words through decode.
//  Elastic 2-stage pipeline with valid/ready on both sides.
// PARAMETERS
//  ADDR_W   32   width of out_addr / base_addr; counter wraps modulo 2**ADDR_W
// PORTS
//  clk        in   1       single clock, all state on rising edge
//  rst        in   1       synchronous, active-high reset
//  base_load  in   1       load address counter from base_addr
//  base_addr  in   ADDR_W  new start address (low 2 bits ignored, forced 0)
//  in_valid   in   1       input micro-op valid
//  in_ready   out  1       input accepted when in_valid & in_ready
//  in_kind    in   4       0 LUI,1 AUIPC,2 JAL,3 JALR,4 BRANCH,5 LOAD,6 STORE,7 OP_IMM,8 OP; 9-15 illegal
//  in_rd      in   5       destination reg
//  in_rs1     in   5       source reg 1
//  in_rs2     in   5       source reg 2
//  in_f3      in   3       funct3
//  in_f7b5    in   1       funct7[5] (SUB/SRA/SRAI select)
//  in_imm     in   32      full-width immediate, byte offset for B/J
//  out_valid  out  1       encoded word valid
//  out_ready  in   1       downstream accepts when out_valid & out_ready
//  out_inst   out  32      encoded instruction
//  out_addr   out  ADDR_W  address assigned to out_inst
//  out_err    out  1       encoding error flag for this word
// BEHAVIOUR
//  - Reset: out_valid=0, out_inst=0, out_addr=0, out_err=0, address counter=0; both stages empty; in_ready=1 next cycle.
//  - Latency: 2 cycles, accept-edge to out_valid; throughput 1 word/cycle while out_ready=1.
//  - Stage 1 registers fields and assigned address; stage 2 registers packed word.
//  - in_ready = !s1_valid | (s1 advances this cycle); no combinational out_ready->in_ready beyond that term.
//  - Backpressure: output holds all outputs stable while out_valid & !out_ready; at most 2 words buffered, never dropped or reordered.
//  - Address: assigned at input acceptance, counter += 4 per accept, wraps at 2**ADDR_W.
//  - base_load alone: counter <= {base_addr[ADDR_W-1:2],2'b00}.
//  - base_load with an accept in the same cycle: accepted word gets the base address; counter <= base+4.
//  - Words already in flight keep their addresses.
//  - Packing: opcode[1:0]=2'b11; opcode[6:2] per kind as in the decoder.
//  - Field placement: rd[11:7], f3[14:12], rs1[19:15], rs2[24:20].
//  - Immediate packing:
//    I: [31:20]=imm[11:0]
//    S: [31:25]=imm[11:5], [11:7]=imm[4:0]
//    B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]
//    U: [31:12]=imm[31:12]
//    J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]
//    OP: [31:25]={1'b0,f7b5,5'b0}
//  - OP_IMM shift (f3=001/101): [31:25]={1'b0,f7b5,5'b0}, [24:20]=imm[4:0].
//  - Unused fields per format are ignored: LUI/AUIPC/JAL f3, rs1, rs2; I-type rs2.
//  - Illegal kind: out_inst=32'h0000_0013 (NOP), out_err=1, unconditionally.
//  - Reset mid-operation: in-flight words discarded, nothing emitted in the reset cycle or after it until new accepts.
// CONFIGURATION
//  IMM_CHECK_EN defined: out_err=1 when the immediate is not representable. Conditions:
//    I/S: imm != sext(imm[11:0])
//    B: imm != sext(imm[12:0]) or imm[0]
//    J: imm != sext(imm[20:0]) or imm[0]
//    U: imm[11:0] != 0
//    shift: imm[31:5] != 0
//  On a range error the truncated word is still emitted.
//  IMM_CHECK_EN undefined: range checking removed; excess bits silently truncated; out_err reflects only illegal kind.
// STRUCTURE
//  - rv_pkg holds:
//    - kind enum kind_e
//    - opcode localparams shared with decode (replacing the RV_* macros)
//    - insttype enum RTYPE..JTYPE
//    - NOP constant
//  - Sub-module inst_pack: purely combinational fields->{inst,err} packer between stage 1 and stage 2.
//    decode is its exact inverse, to be reused by the bench.
// TESTING
//  1. OP_IMM rd=1 rs1=0 f3=0 imm=5 after reset -> out_inst=0x00500093, out_addr=0x0, err=0, 2-cycle latency.
//  2. LUI rd=5 imm=0x12345000 -> 0x123452B7. BRANCH f3=0 rs1=1 rs2=2 imm=-4 -> 0xFE208EE3.
//  3. OP_IMM f3=5 f7b5=1 rd=3 rs1=3 imm=4 (srai) -> 0x4041D193. Pipe each word through decode and match all fields.
//  4. out_ready=0 for 4 cycles while driving 3 words:
//     - in_ready drops after 2 accepts.
//     - After release, 3 words emerge in order at addrs 0x0,0x4,0x8 with no loss.
//  5. base_load=1 base_addr=0xFFFFFFFE with an accept in the same cycle: word addr=0xFFFFFFFC, next addr=0x0 (wrap).
//  6. With IMM_CHECK_EN: STORE imm=2048 -> err=1. in_kind=12 -> 0x00000013, err=1.
//     rst asserted with 2 words in flight -> out_valid=0 next cycle, counter=0.

Source files
------------

// File: rtl/rv_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | rv_pkg : shared RV32I encode/decode kinds, formats and opcode constants |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package rv_pkg;

  typedef enum logic [3:0] {
    K_LUI    = 4'd0,
    K_AUIPC  = 4'd1,
    K_JAL    = 4'd2,
    K_JALR   = 4'd3,
    K_BRANCH = 4'd4,
    K_LOAD   = 4'd5,
    K_STORE  = 4'd6,
    K_OP_IMM = 4'd7,
    K_OP     = 4'd8
  } kind_e;

  typedef enum logic [2:0] {
    RTYPE = 3'd0,
    ITYPE = 3'd1,
    STYPE = 3'd2,
    BTYPE = 3'd3,
    UTYPE = 3'd4,
    JTYPE = 3'd5,
    XTYPE = 3'd6
  } insttype_e;

  localparam logic [6:0] C_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] C_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] C_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] C_OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] C_OPC_OP     = 7'b0110011;

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [3:0]  kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        f7b5;
    logic [31:0] imm;
  } uop_t;

  function automatic insttype_e kind_type(input logic [3:0] kind);
    insttype_e t;
    t = XTYPE;
    case (kind)
      K_LUI, K_AUIPC:          t = UTYPE;
      K_JAL:                   t = JTYPE;
      K_JALR, K_LOAD, K_OP_IMM: t = ITYPE;
      K_BRANCH:                t = BTYPE;
      K_STORE:                 t = STYPE;
      K_OP:                    t = RTYPE;
      default:                 t = XTYPE;
    endcase
    return t;
  endfunction

  function automatic logic [6:0] opcode_of(input logic [3:0] kind);
    logic [6:0] o;
    o = C_NOP[6:0];
    case (kind)
      K_LUI:    o = C_OPC_LUI;
      K_AUIPC:  o = C_OPC_AUIPC;
      K_JAL:    o = C_OPC_JAL;
      K_JALR:   o = C_OPC_JALR;
      K_BRANCH: o = C_OPC_BRANCH;
      K_LOAD:   o = C_OPC_LOAD;
      K_STORE:  o = C_OPC_STORE;
      K_OP_IMM: o = C_OPC_OP_IMM;
      K_OP:     o = C_OPC_OP;
      default:  o = C_NOP[6:0];
    endcase
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_encoder_pack.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | inst_pack : combinational micro-op fields -> RV32I word + error flag    |
// | Range checking present only when IMM_CHECK_EN is defined.   Rev 1.0    |
// +-------------------------------------------------------------------------+
module inst_pack
  import rv_pkg::*;
(
  input  logic [3:0]  i_kind,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_f3,
  input  logic        i_f7b5,
  input  logic [31:0] i_imm,
  output logic [31:0] o_inst,
  output logic        o_err
);

  insttype_e  w_type;
  logic [6:0] w_opc;
  logic       w_shift;
  logic       w_range_err;
  logic [6:0] w_f7;

  assign w_type  = kind_type(i_kind);
  assign w_opc   = opcode_of(i_kind);
  // SLLI/SRLI/SRAI carry funct7 and a 5-bit shamt instead of a 12-bit immediate
  assign w_shift = (i_kind == K_OP_IMM) && (i_f3[1:0] == 2'b01);
  assign w_f7    = {1'b0, i_f7b5, 5'b00000};

  always_comb begin
    o_inst = C_NOP;
    case (w_type)
      RTYPE: o_inst = {w_f7, i_rs2, i_rs1, i_f3, i_rd, w_opc};
      ITYPE: begin
        if (w_shift) o_inst = {w_f7, i_imm[4:0], i_rs1, i_f3, i_rd, w_opc};
        else         o_inst = {i_imm[11:0], i_rs1, i_f3, i_rd, w_opc};
      end
      STYPE: o_inst = {i_imm[11:5], i_rs2, i_rs1, i_f3, i_imm[4:0], w_opc};
      BTYPE: o_inst = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_f3,
                       i_imm[4:1], i_imm[11], w_opc};
      UTYPE: o_inst = {i_imm[31:12], i_rd, w_opc};
      JTYPE: o_inst = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, w_opc};
      default: o_inst = C_NOP;
    endcase
  end

`ifdef IMM_CHECK_EN
  always_comb begin
    w_range_err = 1'b0;
    case (w_type)
      ITYPE: begin
        if (w_shift) w_range_err = |i_imm[31:5];
        else         w_range_err = (i_imm != {{20{i_imm[11]}}, i_imm[11:0]});
      end
      STYPE: w_range_err = (i_imm != {{20{i_imm[11]}}, i_imm[11:0]});
      BTYPE: w_range_err = (i_imm != {{19{i_imm[12]}}, i_imm[12:0]}) || i_imm[0];
      JTYPE: w_range_err = (i_imm != {{11{i_imm[20]}}, i_imm[20:0]}) || i_imm[0];
      UTYPE: w_range_err = |i_imm[11:0];
      default: w_range_err = 1'b0;
    endcase
  end
`else
  assign w_range_err = 1'b0;
`endif

  assign o_err = (w_type == XTYPE) || w_range_err;

endmodule
`default_nettype wire

// File: rtl/inst_encoder.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | inst_encoder : 2-stage elastic RV32I encoder streaming addressed words  |
// | Optional immediate range check via IMM_CHECK_EN.            Rev 1.0    |
// +-------------------------------------------------------------------------+
module inst_encoder
  import rv_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_f3,
  input  logic              in_f7b5,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err
);

  logic              w_s2_free;
  logic              w_s1_adv;
  logic              w_accept;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_assign;
  logic [31:0]       w_pack_inst;
  logic              w_pack_err;

  logic              r_s1_valid;
  uop_t              r_s1_uop;
  logic [ADDR_W-1:0] r_s1_addr;
  logic [ADDR_W-1:0] r_cnt;

  logic              r_out_valid;
  logic [31:0]       r_out_inst;
  logic [ADDR_W-1:0] r_out_addr;
  logic              r_out_err;

  assign w_s2_free = !r_out_valid || out_ready;
  assign w_s1_adv  = r_s1_valid && w_s2_free;
  assign in_ready  = !r_s1_valid || w_s1_adv;
  assign w_accept  = in_valid && in_ready;
  assign w_base    = base_addr & ~ADDR_W'(3);
  // A same-cycle base load takes effect for the word accepted in that cycle
  assign w_assign  = base_load ? w_base : r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= w_assign + ADDR_W'(4);
    end else if (base_load) begin
      r_cnt <= w_base;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_uop.kind <= in_kind;
      r_s1_uop.rd   <= in_rd;
      r_s1_uop.rs1  <= in_rs1;
      r_s1_uop.rs2  <= in_rs2;
      r_s1_uop.f3   <= in_f3;
      r_s1_uop.f7b5 <= in_f7b5;
      r_s1_uop.imm  <= in_imm;
      r_s1_addr     <= w_assign;
    end
  end

  inst_pack u_pack (
    .i_kind (r_s1_uop.kind),
    .i_rd   (r_s1_uop.rd),
    .i_rs1  (r_s1_uop.rs1),
    .i_rs2  (r_s1_uop.rs2),
    .i_f3   (r_s1_uop.f3),
    .i_f7b5 (r_s1_uop.f7b5),
    .i_imm  (r_s1_uop.imm),
    .o_inst (w_pack_inst),
    .o_err  (w_pack_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_inst  <= '0;
      r_out_addr  <= '0;
      r_out_err   <= 1'b0;
    end else if (w_s1_adv) begin
      r_out_valid <= 1'b1;
      r_out_inst  <= w_pack_inst;
      r_out_addr  <= r_s1_addr;
      r_out_err   <= w_pack_err;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_inst  = r_out_inst;
  assign out_addr  = r_out_addr;
  assign out_err   = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_inst_encoder : directed + random bench with decode-based reference   |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        base_load;
  logic [31:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_kind;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_f3;
  logic        in_f7b5;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        out_err;

  inst_encoder #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .base_load(base_load), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_f3(in_f3),
    .in_f7b5(in_f7b5), .in_imm(in_imm), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr),
    .out_err(out_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  kind;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        f7b5;
    logic [31:0] imm;
  } exp_t;

  typedef struct packed {
    logic [3:0]  kind;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } canon_t;

  exp_t q[$];

  // value of the low n bits of v read as an n-bit two's-complement number
  function automatic logic [31:0] sext(input logic [31:0] v, input int n);
    logic [31:0] m;
    m = v & ((32'd1 << n) - 32'd1);
    if (m >= (32'd1 << (n - 1))) m = m - (32'd1 << n);
    return m;
  endfunction

  function automatic bit is_shift(input exp_t e);
    return (e.kind == 4'd7) && (e.f3 == 3'd1 || e.f3 == 3'd5);
  endfunction

  // what decode should recover from a correctly packed word
  function automatic canon_t exp_canon(input exp_t e);
    canon_t c;
    c = '0;
    c.kind = e.kind;
    case (e.kind)
      4'd0, 4'd1: begin c.rd = e.rd; c.imm = e.imm & 32'hFFFF_F000; end
      4'd2:       begin c.rd = e.rd; c.imm = sext(e.imm, 21) & ~32'd1; end
      4'd3, 4'd5, 4'd7: begin
        c.rd = e.rd; c.rs1 = e.rs1; c.f3 = e.f3;
        if (is_shift(e)) begin
          c.f7  = e.f7b5 ? 7'h20 : 7'h00;
          c.imm = e.imm % 32;
        end else c.imm = sext(e.imm, 12);
      end
      4'd4: begin c.rs1 = e.rs1; c.rs2 = e.rs2; c.f3 = e.f3; c.imm = sext(e.imm, 13) & ~32'd1; end
      4'd6: begin c.rs1 = e.rs1; c.rs2 = e.rs2; c.f3 = e.f3; c.imm = sext(e.imm, 12); end
      default: begin
        c.rd = e.rd; c.rs1 = e.rs1; c.rs2 = e.rs2; c.f3 = e.f3;
        c.f7 = e.f7b5 ? 7'h20 : 7'h00;
      end
    endcase
    return c;
  endfunction

  function automatic canon_t dec_canon(input logic [31:0] w);
    canon_t c;
    c = '0;
    case (w[6:0])
      7'h37: c.kind = 4'd0;
      7'h17: c.kind = 4'd1;
      7'h6F: c.kind = 4'd2;
      7'h67: c.kind = 4'd3;
      7'h63: c.kind = 4'd4;
      7'h03: c.kind = 4'd5;
      7'h23: c.kind = 4'd6;
      7'h13: c.kind = 4'd7;
      7'h33: c.kind = 4'd8;
      default: c.kind = 4'd15;
    endcase
    case (c.kind)
      4'd0, 4'd1: begin c.rd = w[11:7]; c.imm = {w[31:12], 12'b0}; end
      4'd2: begin c.rd = w[11:7]; c.imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0}; end
      4'd3, 4'd5, 4'd7: begin
        c.rd = w[11:7]; c.rs1 = w[19:15]; c.f3 = w[14:12];
        if (c.kind == 4'd7 && (c.f3 == 3'd1 || c.f3 == 3'd5)) begin
          c.f7 = w[31:25]; c.imm = {27'b0, w[24:20]};
        end else c.imm = {{20{w[31]}}, w[31:20]};
      end
      4'd4: begin
        c.rs1 = w[19:15]; c.rs2 = w[24:20]; c.f3 = w[14:12];
        c.imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
      end
      4'd6: begin
        c.rs1 = w[19:15]; c.rs2 = w[24:20]; c.f3 = w[14:12];
        c.imm = {{20{w[31]}}, w[31:25], w[11:7]};
      end
      4'd8: begin
        c.rd = w[11:7]; c.rs1 = w[19:15]; c.rs2 = w[24:20]; c.f3 = w[14:12]; c.f7 = w[31:25];
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic exp_err(input exp_t e);
    int s;
    s = $signed(e.imm);
    if (e.kind > 4'd8) return 1'b1;
`ifdef IMM_CHECK_EN
    case (e.kind)
      4'd0, 4'd1: return (e.imm % 4096) != 0;
      4'd2: return (s < -(1 << 20)) || (s > (1 << 20) - 1) || (e.imm % 2 != 0);
      4'd4: return (s < -4096) || (s > 4095) || (e.imm % 2 != 0);
      4'd8: return 1'b0;
      default: begin
        if (is_shift(e)) return e.imm > 32'd31;
        return (s < -2048) || (s > 2047);
      end
    endcase
`else
    return (s == 0) && 1'b0;
`endif
  endfunction

  // reference model: tracks accepts and address assignment, checks every output transfer
  logic [31:0] m_cnt;
  logic        m_hold;
  logic [31:0] m_hold_inst, m_hold_addr;
  logic        m_hold_err;
  exp_t        m_e;

  initial begin
    m_cnt  = 32'd0;
    m_hold = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        m_cnt  = 32'd0;
        m_hold = 1'b0;
      end else begin
        if (m_hold) begin
          check("hold_valid", out_valid, 1'b1);
          check("hold_inst", out_inst, m_hold_inst);
          check("hold_addr", out_addr, m_hold_addr);
          check("hold_err", out_err, m_hold_err);
        end
        m_hold      = out_valid && !out_ready;
        m_hold_inst = out_inst;
        m_hold_addr = out_addr;
        m_hold_err  = out_err;
        if (out_valid && out_ready) begin
          check("out_has_expected", q.size() != 0, 1'b1);
          if (q.size() != 0) begin
            m_e = q.pop_front();
            check("out_addr", out_addr, m_e.addr);
            check("out_err", out_err, exp_err(m_e));
            if (m_e.kind > 4'd8) check("out_nop", out_inst, 32'h0000_0013);
            else                 check("out_fields", dec_canon(out_inst), exp_canon(m_e));
          end
        end
        if (in_valid && in_ready) begin
          m_e.addr = base_load ? (base_addr & ~32'd3) : m_cnt;
          m_e.kind = in_kind; m_e.rd = in_rd; m_e.rs1 = in_rs1; m_e.rs2 = in_rs2;
          m_e.f3 = in_f3; m_e.f7b5 = in_f7b5; m_e.imm = in_imm;
          q.push_back(m_e);
          m_cnt = m_e.addr + 32'd4;
        end else if (base_load) begin
          m_cnt = base_addr & ~32'd3;
        end
      end
    end
  end

  task automatic set_uop(input int k, input int rd, input int rs1, input int rs2,
                         input int f3, input int f7b5, input logic [31:0] imm);
    in_kind = 4'(k); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
    in_f3 = 3'(f3); in_f7b5 = 1'(f7b5); in_imm = imm;
  endtask

  task automatic send(input int k, input int rd, input int rs1, input int rs2,
                      input int f3, input int f7b5, input logic [31:0] imm);
    bit acc;
    int t;
    acc = 0;
    t = 0;
    set_uop(k, rd, rs1, rs2, f3, f7b5, imm);
    in_valid = 1'b1;
    while (!acc && t < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      t++;
    end
    if (!acc) check("send_accept_timeout", acc, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] inst,
                            input logic [31:0] addr, input logic err);
    bit seen;
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        seen = 1;
        check({tag, "_inst"}, out_inst, inst);
        check({tag, "_addr"}, out_addr, addr);
        check({tag, "_err"}, out_err, err);
      end
      @(posedge clk); #1;
    end
    check({tag, "_seen"}, seen, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; base_load = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic        store_err;
  int          acc_n, got_n;

  initial begin
    rst = 1'b1; base_load = 1'b0; base_addr = '0; in_valid = 1'b0; out_ready = 1'b1;
    set_uop(0, 0, 0, 0, 0, 0, 32'd0);
`ifdef IMM_CHECK_EN
    store_err = 1'b1;
`else
    store_err = 1'b0;
`endif
    do_reset();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_addr", out_addr, 32'd0);
    check("rst_out_err", out_err, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);

    // two-cycle latency from the accepting edge
    send(7, 1, 0, 0, 0, 0, 32'd5);
    check("lat_edge1_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    check("lat_edge2_valid", out_valid, 1'b1);
    check("addi_inst", out_inst, 32'h0050_0093);
    check("addi_addr", out_addr, 32'h0);
    check("addi_err", out_err, 1'b0);
    @(posedge clk); #1;

    send(0, 5, 0, 0, 0, 0, 32'h1234_5000);
    expect_out("lui", 32'h1234_52B7, 32'h4, 1'b0);
    send(4, 0, 1, 2, 0, 0, 32'hFFFF_FFFC);
    expect_out("beq", 32'hFE20_8EE3, 32'h8, 1'b0);
    send(7, 3, 3, 0, 5, 1, 32'd4);
    expect_out("srai", 32'h4041_D193, 32'hC, 1'b0);

    // backpressure: three words while the output is stalled for four cycles
    do_reset();
    out_ready = 1'b0;
    acc_n = 0;
    set_uop(7, 1, 0, 0, 0, 0, 32'd0);
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (in_ready) acc_n++;
      @(posedge clk); #1;
      if (acc_n < 3) set_uop(7, acc_n + 1, 0, 0, 0, 0, 32'(acc_n));
      else in_valid = 1'b0;
    end
    check("bp_accepts", acc_n, 2);
    check("bp_in_ready_low", in_ready, 1'b0);
    out_ready = 1'b1;
    got_n = 0;
    for (int c = 0; c < 20 && got_n < 3; c++) begin
      @(negedge clk);
      if (in_valid && in_ready) acc_n++;
      if (out_valid) begin
        check("bp_order_addr", out_addr, 32'(got_n * 4));
        got_n++;
      end
      @(posedge clk); #1;
      if (acc_n >= 3) in_valid = 1'b0;
    end
    check("bp_words_out", got_n, 3);

    // base load together with an accept, then counter wrap
    base_load = 1'b1; base_addr = 32'hFFFF_FFFE;
    send(7, 2, 0, 0, 0, 0, 32'd1);
    base_load = 1'b0;
    expect_out("base_word", 32'h0010_0113, 32'hFFFF_FFFC, 1'b0);
    send(7, 2, 0, 0, 0, 0, 32'd2);
    expect_out("wrap_word", 32'h0020_0113, 32'h0, 1'b0);

    send(12, 1, 2, 3, 4, 1, 32'hDEAD_BEEF);
    expect_out("illegal", 32'h0000_0013, 32'h4, 1'b1);
    send(6, 0, 0, 0, 2, 0, 32'd2048);
    expect_out("store_2048", 32'h8000_2023, 32'h8, store_err);

    // reset with two words in flight
    out_ready = 1'b0;
    send(7, 1, 0, 0, 0, 0, 32'd7);
    send(7, 2, 0, 0, 0, 0, 32'd8);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_addr", out_addr, 32'h0);
    repeat (3) @(posedge clk);
    #1 check("midrst_quiet", out_valid, 1'b0);
    out_ready = 1'b1;
    send(7, 4, 0, 0, 0, 0, 32'd9);
    expect_out("post_rst", 32'h0090_0213, 32'h0, 1'b0);

    // randomized traffic, scored by the monitor
    for (int c = 0; c < 3000; c++) begin
      int r;
      logic [31:0] imm;
      r = $urandom_range(0, 19);
      case ($urandom_range(0, 3))
        0: imm = $urandom;
        1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: imm = $urandom & 32'hFFFF_F000;
        default: imm = 32'($urandom_range(0, 40));
      endcase
      set_uop(r < 18 ? r % 9 : $urandom_range(9, 15), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 7),
              $urandom_range(0, 1), imm);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      base_load = ($urandom_range(0, 31) == 0);
      base_addr = $urandom;
      rst       = ($urandom_range(0, 499) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; base_load = 1'b0; rst = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 20 && q.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    check("drain_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
